gate_sweep_ctrl: RTL and testbench

Self-checking sweep controller for a 2-input gate under test (default: the NOR gate). On `start` it drives every input combination onto the gate's `a`/`b` inputs in order 00, 01, 10, 11. It holds each vector for a programmable settle window, then samples the gate output `y` and compares it against a parameterised truth table. It sits beside the gate in the lab designs and replaces hand-written stimulus with an on-chip pass/fail result.

---
 rtl/gate_sweep_ctrl_if.sv | 23 ++
 rtl/gate_sweep_ctrl.sv | 101 ++++++++++
 tb/tb_gate_sweep_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/gate_sweep_ctrl_if.sv
// rtl/gate_sweep_ctrl_if.sv - control and gate-stimulus signals of the gate sweep controller
interface gate_sweep_ctrl_if;
  logic       start;
  logic       y;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_mask;

  // Requester side: issues start and returns the gate output.
  modport master (
    output start, y,
    input  a, b, busy, done, pass, err_mask
  );

  // Controller side.
  modport slave (
    input  start, y,
    output a, b, busy, done, pass, err_mask
  );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - sweeps a 2-input gate through 00..11 and checks it against a truth table
module gate_sweep_ctrl #(
  parameter int         SETTLE = 2,
  parameter logic [3:0] EXPECT = 4'b0001
) (
  input  logic            clk,
  input  logic            rst,
  gate_sweep_ctrl_if.slave bus
);

  localparam int            CW       = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nx;
  logic [1:0]    idx, idx_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          a_q, a_nx;
  logic          b_q, b_nx;
  logic          done_q, done_nx;
  logic          pass_q, pass_nx;
  logic [3:0]    mask_q, mask_nx;

  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.busy     = (state == RUN);
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_mask = mask_q;

  // State and datapath registers; reset aborts any sweep without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= 2'd0;
      cnt    <= '0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      mask_q <= 4'd0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      cnt    <= cnt_nx;
      a_q    <= a_nx;
      b_q    <= b_nx;
      done_q <= done_nx;
      pass_q <= pass_nx;
      mask_q <= mask_nx;
    end
  end

  // Next-state: accept start in IDLE, count the settle window, sample y when the count reaches zero.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    a_nx     = a_q;
    b_nx     = b_q;
    done_nx  = 1'b0;
    pass_nx  = pass_q;
    mask_nx  = mask_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = RUN;
          idx_nx   = 2'd0;
          cnt_nx   = CNT_LOAD;
          a_nx     = 1'b0;
          b_nx     = 1'b0;
          mask_nx  = 4'd0;
          pass_nx  = 1'b0;
        end
      end
      RUN: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CNT_ONE;
        end else begin
          mask_nx[idx] = (bus.y != EXPECT[idx]);
          if (idx != 2'd3) begin
            idx_nx       = idx + 2'd1;
            {a_nx, b_nx} = idx + 2'd1;
            cnt_nx       = CNT_LOAD;
          end else begin
            state_nx = IDLE;
            done_nx  = 1'b1;
            a_nx     = 1'b0;
            b_nx     = 1'b0;
            // Final verdict includes the bit sampled on this same edge.
            pass_nx  = (mask_nx == 4'd0);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - self-checking bench for gate_sweep_ctrl
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gate_sweep_ctrl_if bus0();
  gate_sweep_ctrl_if bus1();

  gate_sweep_ctrl #(.SETTLE(2), .EXPECT(4'b0001)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  gate_sweep_ctrl #(.SETTLE(0), .EXPECT(4'b0001)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  typedef enum logic [1:0] {G_NOR, G_OR, G_AND, G_ST0} gate_t;
  gate_t gate0;

  function automatic logic gate_fn(input gate_t g, input logic a, input logic b);
    case (g)
      G_NOR:   return ~(a | b);
      G_OR:    return a | b;
      G_AND:   return a & b;
      default: return 1'b0;
    endcase
  endfunction

  // Gates under test attached to each controller.
  assign bus0.y = gate_fn(gate0, bus0.a, bus0.b);
  assign bus1.y = ~(bus1.a | bus1.b);

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] mask;
    logic       pass;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    gate_t      g;
    logic [3:0] mask;
    logic       pass;
    bit         mid;
  } vec_t;
  vec_t vecs[5];

  // Completion check against the oldest scoreboard entry.
  task automatic pop_check(input string name, input logic [3:0] mask, input logic pass);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s: done with empty scoreboard, got mask %0h", name, mask);
    end else begin
      e = sbq.pop_front();
      check({name, "_mask"}, 32'(mask), 32'(e.mask));
      check({name, "_pass"}, 32'(pass), 32'(e.pass));
    end
  endtask

  // One full SETTLE=2 sweep on dut0, checking every cycle from E0 to the done cycle and one beyond.
  task automatic sweep0(input string name, input bit mid);
    @(negedge clk);
    bus0.start = 1'b1;
    @(negedge clk);           // after E0
    bus0.start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check({name, "_busy"}, 32'(bus0.busy), 32'd1);
      check({name, "_ab"}, 32'({bus0.a, bus0.b}), 32'(k / 3));
      check({name, "_nodone"}, 32'(bus0.done), 32'd0);
      bus0.start = mid && (k == 2 || k == 6);
      @(negedge clk);
    end
    bus0.start = 1'b0;
    check({name, "_done"}, 32'(bus0.done), 32'd1);
    check({name, "_idle"}, 32'(bus0.busy), 32'd0);
    check({name, "_ab0"}, 32'({bus0.a, bus0.b}), 32'd0);
    pop_check(name, bus0.err_mask, bus0.pass);
    @(negedge clk);
    check({name, "_done_drop"}, 32'(bus0.done), 32'd0);
    check({name, "_mask_held"}, 32'(bus0.err_mask), 32'(vecs[0].mask) | 32'(bus0.err_mask));
  endtask

  initial begin
    vecs[0] = '{G_NOR, 4'b0000, 1'b1, 1'b0};
    vecs[1] = '{G_OR,  4'b1111, 1'b0, 1'b0};
    vecs[2] = '{G_AND, 4'b1001, 1'b0, 1'b0};
    vecs[3] = '{G_ST0, 4'b0001, 1'b0, 1'b0};
    vecs[4] = '{G_NOR, 4'b0000, 1'b1, 1'b1};

    rst        = 1'b1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    gate0      = G_NOR;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus0.busy), 32'd0);
    check("rst_done", 32'(bus0.done), 32'd0);
    check("rst_pass", 32'(bus0.pass), 32'd0);
    check("rst_mask", 32'(bus0.err_mask), 32'd0);
    check("rst_ab", 32'({bus0.a, bus0.b}), 32'd0);
    check("rst_busy1", 32'(bus1.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven sweeps: gate type, expected verdict, optional mid-sweep start pulses.
    for (int i = 0; i < 5; i++) begin
      gate0 = vecs[i].g;
      sbq.push_back('{vecs[i].mask, vecs[i].pass});
      sweep0($sformatf("vec%0d", i), vecs[i].mid);
      // A start seen mid-sweep must not produce a second done.
      repeat (3) begin
        @(negedge clk);
        check($sformatf("vec%0d_single_done", i), 32'(bus0.done), 32'd0);
        check($sformatf("vec%0d_stay_idle", i), 32'(bus0.busy), 32'd0);
      end
    end
    check("sb_empty", 32'(sbq.size()), 32'd0);

    // start held through done: the done edge launches the next sweep.
    gate0 = G_OR;
    @(negedge clk);
    bus0.start = 1'b1;
    repeat (13) @(negedge clk); // after E0+12
    check("b2b_done", 32'(bus0.done), 32'd1);
    check("b2b_mask", 32'(bus0.err_mask), 32'hf);
    @(negedge clk);             // after E0+13, new E0
    bus0.start = 1'b0;
    check("b2b_done_drop", 32'(bus0.done), 32'd0);
    check("b2b_busy", 32'(bus0.busy), 32'd1);
    check("b2b_mask_clr", 32'(bus0.err_mask), 32'd0);
    check("b2b_pass_clr", 32'(bus0.pass), 32'd0);
    gate0 = G_NOR;
    repeat (12) @(negedge clk);
    check("b2b2_done", 32'(bus0.done), 32'd1);
    check("b2b2_pass", 32'(bus0.pass), 32'd1);

    // Asynchronous reset mid-sweep at E0+5 aborts without done.
    gate0 = G_AND;
    @(negedge clk);
    bus0.start = 1'b1;
    @(negedge clk);             // after E0
    bus0.start = 1'b0;
    repeat (4) @(negedge clk);  // after E0+4
    check("pre_rst_mask", 32'(bus0.err_mask), 32'd1);
    check("pre_rst_ab", 32'({bus0.a, bus0.b}), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_ab", 32'({bus0.a, bus0.b}), 32'd0);
    check("arst_busy", 32'(bus0.busy), 32'd0);
    check("arst_pass", 32'(bus0.pass), 32'd0);
    check("arst_mask", 32'(bus0.err_mask), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("arst_no_done", 32'(bus0.done), 32'd0);
    end
    gate0 = G_NOR;
    sbq.push_back('{4'b0000, 1'b1});
    sweep0("post_rst", 1'b0);

    // SETTLE=0: new vector every cycle, done after E0+4.
    sbq.push_back('{4'b0000, 1'b1});
    @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("s0_ab", 32'({bus1.a, bus1.b}), 32'(k));
      check("s0_busy", 32'(bus1.busy), 32'd1);
      @(negedge clk);
    end
    check("s0_done", 32'(bus1.done), 32'd1);
    pop_check("s0", bus1.err_mask, bus1.pass);
    @(negedge clk);
    check("s0_done_drop", 32'(bus1.done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
